// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the EX operand forwarding / load-use hazard controller.
// Holds the operand mux select encoding, the register index width and the in-flight entry format.
package fwd_hazard_unit_pkg;

   localparam int REG_AW = 5;
   localparam int ZERO_REG = 0;

   typedef enum logic [1:0] {
      SEL_RF    = 2'd0,
      SEL_EXMEM = 2'd1,
      SEL_MEMWB = 2'd2,
      SEL_WB    = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              is_load;
   } pipe_entry_t;

   localparam pipe_entry_t ENTRY_EMPTY = '0;

   // A producer feeds a source only if it really writes that register and the
   // register is not the hardwired zero.
   function automatic logic entry_hit(
      input logic              valid,
      input logic              we,
      input logic [REG_AW-1:0] rd,
      input logic [REG_AW-1:0] src,
      input logic              use_src,
      input logic [REG_AW-1:0] zero_idx
   );
      return valid & we & use_src & (rd == src) & (src != zero_idx);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Per-operand forwarding select: picks the youngest in-flight producer of the source register.
// Purely combinational; evaluated on the entries as they stand before the clock edge.
module fwd_match #(
   parameter int REG_AW   = fwd_hazard_unit_pkg::REG_AW,
   parameter int ZERO_REG = fwd_hazard_unit_pkg::ZERO_REG
) (
   input  logic [REG_AW-1:0]                src,
   input  logic                             use_src,
   input  fwd_hazard_unit_pkg::pipe_entry_t ex_e,
   input  fwd_hazard_unit_pkg::pipe_entry_t mem_e,
   input  fwd_hazard_unit_pkg::pipe_entry_t wb_e,
   output logic [1:0]                       sel
);
   import fwd_hazard_unit_pkg::*;

   localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   assign ex_hit  = entry_hit(ex_e.valid,  ex_e.we,  ex_e.rd,  src, use_src, ZERO_IDX);
   assign mem_hit = entry_hit(mem_e.valid, mem_e.we, mem_e.rd, src, use_src, ZERO_IDX);
   assign wb_hit  = entry_hit(wb_e.valid,  wb_e.we,  wb_e.rd,  src, use_src, ZERO_IDX);

   always_comb begin
      sel = SEL_RF;
      if (ex_hit) begin
         sel = SEL_EXMEM;
      end else if (mem_hit) begin
         sel = SEL_MEMWB;
      end else if (wb_hit) begin
         sel = SEL_WB;
      end
   end

   // Load-ness only matters to the stall check in the parent.
   logic unused_is_load;
   assign unused_is_load = ex_e.is_load ^ mem_e.is_load ^ wb_e.is_load;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks EX/MEM/WB destinations, registers the EX operand mux selects and
// stalls ID for one cycle when a consumer directly follows a load.
module fwd_hazard_unit #(
   parameter int REG_AW   = fwd_hazard_unit_pkg::REG_AW,
   parameter int ZERO_REG = fwd_hazard_unit_pkg::ZERO_REG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              pipe_hold,
   input  logic              flush,
   output logic              stall_id,
   output logic              ex_valid,
   output logic [1:0]        ex_sel_a,
   output logic [1:0]        ex_sel_b
);
   import fwd_hazard_unit_pkg::*;

   localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

   pipe_entry_t ex_q,  ex_d;
   pipe_entry_t mem_q, mem_d;
   pipe_entry_t wb_q,  wb_d;
   logic [1:0]  ex_sel_a_q, ex_sel_a_d;
   logic [1:0]  ex_sel_b_q, ex_sel_b_d;

   logic [1:0]  id_sel_a;
   logic [1:0]  id_sel_b;
   logic        load_use;

   fwd_match #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
   ) u_match_a (
      .src     (id_rs),
      .use_src (id_use_rs),
      .ex_e    (ex_q),
      .mem_e   (mem_q),
      .wb_e    (wb_q),
      .sel     (id_sel_a)
   );

   fwd_match #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
   ) u_match_b (
      .src     (id_rt),
      .use_src (id_use_rt),
      .ex_e    (ex_q),
      .mem_e   (mem_q),
      .wb_e    (wb_q),
      .sel     (id_sel_b)
   );

   // A load's data exists only at the end of MEM, so a consumer right behind it must wait one cycle.
   assign load_use = ex_q.is_load &
                     (entry_hit(ex_q.valid, ex_q.we, ex_q.rd, id_rs, id_use_rs, ZERO_IDX) |
                      entry_hit(ex_q.valid, ex_q.we, ex_q.rd, id_rt, id_use_rt, ZERO_IDX));

   assign stall_id = id_valid & ~flush & load_use;

   always_comb begin
      ex_d       = ex_q;
      mem_d      = mem_q;
      wb_d       = wb_q;
      ex_sel_a_d = ex_sel_a_q;
      ex_sel_b_d = ex_sel_b_q;

      // A flushed EX instruction is dead, so it must not reach MEM as a forwarding source.
      if (!pipe_hold) begin
         wb_d  = mem_q;
         mem_d = flush ? ENTRY_EMPTY : ex_q;
      end

      if (flush) begin
         ex_d       = ENTRY_EMPTY;
         ex_sel_a_d = SEL_RF;
         ex_sel_b_d = SEL_RF;
      end else if (!pipe_hold) begin
         if (stall_id || !id_valid) begin
            ex_d       = ENTRY_EMPTY;
            ex_sel_a_d = SEL_RF;
            ex_sel_b_d = SEL_RF;
         end else begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = id_rd;
            ex_d.we      = id_we;
            ex_d.is_load = id_is_load;
            ex_sel_a_d   = id_sel_a;
            ex_sel_b_d   = id_sel_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q       <= ENTRY_EMPTY;
         mem_q      <= ENTRY_EMPTY;
         wb_q       <= ENTRY_EMPTY;
         ex_sel_a_q <= SEL_RF;
         ex_sel_b_q <= SEL_RF;
      end else begin
         ex_q       <= ex_d;
         mem_q      <= mem_d;
         wb_q       <= wb_d;
         ex_sel_a_q <= ex_sel_a_d;
         ex_sel_b_q <= ex_sel_b_d;
      end
   end

   assign ex_valid = ex_q.valid;
   assign ex_sel_a = ex_sel_a_q;
   assign ex_sel_b = ex_sel_b_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit: each row is one ID-stage cycle with its
// expected stall and the EX outputs expected after the following clock edge.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic [4:0] id_rd;
   logic       id_we;
   logic       id_is_load;
   logic       pipe_hold;
   logic       flush;
   logic       stall_id;
   logic       ex_valid;
   logic [1:0] ex_sel_a;
   logic [1:0] ex_sel_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(
      .REG_AW   (5),
      .ZERO_REG (0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_use_rs  (id_use_rs),
      .id_use_rt  (id_use_rt),
      .id_rd      (id_rd),
      .id_we      (id_we),
      .id_is_load (id_is_load),
      .pipe_hold  (pipe_hold),
      .flush      (flush),
      .stall_id   (stall_id),
      .ex_valid   (ex_valid),
      .ex_sel_a   (ex_sel_a),
      .ex_sel_b   (ex_sel_b)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] rd;
      logic       we;
      logic       ld;
      logic       hold;
      logic       fl;
      logic       e_stall;
      logic       e_exv;
      logic [1:0] e_sa;
      logic [1:0] e_sb;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int v, input int rs, input int urs, input int rt,
                               input int urt, input int rd, input int we, input int ld,
                               input int hold, input int fl, input int es, input int ev,
                               input int sa, input int sb);
      vec_t r;
      r.v = 1'(v);   r.rs = 5'(rs);  r.urs = 1'(urs);  r.rt = 5'(rt);   r.urt = 1'(urt);
      r.rd = 5'(rd); r.we = 1'(we);  r.ld = 1'(ld);    r.hold = 1'(hold); r.fl = 1'(fl);
      r.e_stall = 1'(es); r.e_exv = 1'(ev); r.e_sa = 2'(sa); r.e_sb = 2'(sb);
      return r;
   endfunction

   function automatic vec_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t t);
      id_valid   = t.v;
      id_rs      = t.rs;
      id_use_rs  = t.urs;
      id_rt      = t.rt;
      id_use_rt  = t.urt;
      id_rd      = t.rd;
      id_we      = t.we;
      id_is_load = t.ld;
      pipe_hold  = t.hold;
      flush      = t.fl;
   endtask

   // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
   task automatic step(input vec_t t, input int idx);
      apply(t);
      #1;
      chk("stall_id", idx, {1'b0, stall_id}, {1'b0, t.e_stall});
      @(posedge clk);
      #1;
      chk("ex_valid", idx, {1'b0, ex_valid}, {1'b0, t.e_exv});
      chk("ex_sel_a", idx, ex_sel_a, t.e_sa);
      chk("ex_sel_b", idx, ex_sel_b, t.e_sb);
   endtask

   initial begin
      // ALU chain: add r3<-r1,r2 ; sub r5<-r3,r4
      tbl.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 3, 1, 4, 1, 5, 1, 0, 0, 0,   0, 1, 1, 0));
      repeat (3) tbl.push_back(nop());
      // Priority: three writers of r3, reader immediately / after one nop / after two nops
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 2, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 3, 1, 4, 1, 6, 1, 0, 0, 0,   0, 1, 1, 0));
      repeat (3) tbl.push_back(nop());
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 2, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(nop());
      tbl.push_back(mk(1, 3, 1, 4, 1, 6, 1, 0, 0, 0,   0, 1, 2, 0));
      repeat (3) tbl.push_back(nop());
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 2, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(nop());
      tbl.push_back(nop());
      tbl.push_back(mk(1, 3, 1, 4, 1, 6, 1, 0, 0, 0,   0, 1, 3, 0));
      repeat (3) tbl.push_back(nop());
      // Load-use: lw r7 ; add r8<-r7,r7 (one bubble), then back-to-back dependent loads
      tbl.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0,   1, 0, 0, 0));
      tbl.push_back(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0,   0, 1, 2, 2));
      tbl.push_back(mk(1, 8, 1, 0, 0, 9, 1, 1, 0, 0,   0, 1, 1, 0));
      tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, 1, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, 1, 0, 0,  0, 1, 2, 0));
      tbl.push_back(mk(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 0, 1, 2, 0));
      repeat (3) tbl.push_back(nop());
      // r0, unused sources and non-writing entries
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 1, 2, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 1, 2, 0, 4, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 5, 0, 6, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 9, 0, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 9, 1, 6, 1, 12, 1, 0, 0, 0,  0, 1, 0, 2));
      repeat (3) tbl.push_back(nop());
      // Hold for three cycles during a load-use stall
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0,   0, 1, 1, 0));
      repeat (3) tbl.push_back(mk(1, 7, 1, 1, 1, 8, 1, 0, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0,   1, 0, 0, 0));
      tbl.push_back(mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0,   0, 1, 2, 3));
      // Flush together with hold: EX killed, MEM/WB kept
      tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0,   0, 1, 0, 0));
      tbl.push_back(mk(1, 4, 1, 0, 0, 5, 1, 0, 1, 1,   0, 0, 0, 0));
      tbl.push_back(mk(1, 3, 1, 2, 1, 6, 1, 0, 0, 0,   0, 1, 2, 3));
      // Fill all three stages ahead of the mid-stream reset
      tbl.push_back(mk(1, 6, 1, 0, 0, 10, 1, 0, 0, 0,  0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0,  0, 1, 0, 0));
      tbl.push_back(mk(1, 10, 1, 0, 0, 11, 1, 1, 0, 0, 0, 1, 2, 0));

      rst_n = 1'b0;
      apply(nop());
      #2;
      chk("reset_stall", 0, {1'b0, stall_id}, 2'd0);
      chk("reset_ex_valid", 0, {1'b0, ex_valid}, 2'd0);
      chk("reset_sel_a", 0, ex_sel_a, 2'd0);
      chk("reset_sel_b", 0, ex_sel_b, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) step(tbl[i], i);

      // Consumer of lw r11 is stalling; pull reset mid-cycle and expect an immediate clear.
      apply(mk(1, 11, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("pre_rst_stall", 1, {1'b0, stall_id}, 2'd1);
      chk("pre_rst_ex_valid", 1, {1'b0, ex_valid}, 2'd1);
      chk("pre_rst_sel_a", 1, ex_sel_a, 2'd2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_stall", 1, {1'b0, stall_id}, 2'd0);
      chk("async_rst_ex_valid", 1, {1'b0, ex_valid}, 2'd0);
      chk("async_rst_sel_a", 1, ex_sel_a, 2'd0);
      chk("async_rst_sel_b", 1, ex_sel_b, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_stall", 2, {1'b0, stall_id}, 2'd0);
      @(posedge clk);
      #1;
      chk("post_rst_ex_valid", 2, {1'b0, ex_valid}, 2'd1);
      chk("post_rst_sel_a", 2, ex_sel_a, 2'd0);
      chk("post_rst_sel_b", 2, ex_sel_b, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
